// File: rtl/pulse_modulator_pkg.sv
// Shared definitions for the readout pulse modulator: sizes, vector types,
// FSM state codes and the quarter-wave sine table generator.
package pulse_modulator_pkg;

  localparam int LANES = 5;    // samples per clk100 beat
  localparam int DW    = 16;   // signed sample / amplitude width
  localparam int PW    = 14;   // phase width, full turn = 2^PW
  localparam int LEN_W = 11;   // pulse length in beats
  localparam int QW    = PW - 2;        // quarter-wave address width
  localparam int QN    = 2 ** QW;       // quarter-wave entries

  typedef logic [LANES-1:0][DW-1:0] sample_vec_t;
  typedef logic [LANES-1:0][PW-1:0] phase_vec_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam real TWO_PI = 6.283185307179586;

  // round(32767*sin(2*pi*idx/2^PW)); only used to fill a constant table
  function automatic logic signed [DW-1:0] quarter_sin(input int idx);
    real r;
    r = 32767.0 * $sin(TWO_PI * real'(idx) / real'(2 ** PW));
    return DW'(int'(r));
  endfunction

endpackage

// File: rtl/pulse_modulator_sincos_lut.sv
// Per-lane cos/sin lookup with a registered one-cycle read. A single
// quarter-wave sine table is folded over the four quadrants.
module pulse_modulator_sincos_lut
  import pulse_modulator_pkg::*;
(
  input  logic                 clk100,
  input  logic                 reset_n,
  input  logic [PW-1:0]        phase,
  output logic signed [DW-1:0] cos_val,
  output logic signed [DW-1:0] sin_val
);

  logic signed [DW-1:0] qtab [QN];

  for (genvar g = 0; g < QN; g++) begin : g_tab
    assign qtab[g] = quarter_sin(g);
  end

  logic [1:0]           quad_s;
  logic [QW-1:0]        off_s;
  logic [QW:0]          cmp_idx_s;
  logic signed [DW-1:0] dir_s;
  logic signed [DW-1:0] cmp_s;
  logic signed [DW-1:0] cos_s;
  logic signed [DW-1:0] sin_s;

  // Fold the phase into one quadrant; cmp_s is sin(pi/2 - theta) = cos(theta)
  always_comb begin
    quad_s    = phase[PW-1:PW-2];
    off_s     = phase[QW-1:0];
    cmp_idx_s = {1'b1, {QW{1'b0}}} - {1'b0, off_s};
    dir_s     = qtab[off_s];
    if (cmp_idx_s[QW]) begin
      cmp_s = 16'sd32767;          // offset 0: the quarter point itself
    end else begin
      cmp_s = qtab[cmp_idx_s[QW-1:0]];
    end
    case (quad_s)
      2'd0: begin cos_s = cmp_s;  sin_s = dir_s;  end
      2'd1: begin cos_s = -dir_s; sin_s = cmp_s;  end
      2'd2: begin cos_s = -cmp_s; sin_s = -dir_s; end
      2'd3: begin cos_s = dir_s;  sin_s = -cmp_s; end
      default: begin cos_s = 16'sd0; sin_s = 16'sd0; end
    endcase
  end

  // Registered table read
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      cos_val <= 16'sd0;
      sin_val <= 16'sd0;
    end else begin
      cos_val <= cos_s;
      sin_val <= sin_s;
    end
  end

endmodule

// File: rtl/pulse_modulator.sv
// Rectangular readout pulse generator: 5 I/Q samples per clk100 beat,
// upconverted by a phase accumulator, with per-lane phases exported in
// step with the data so the receiver can derotate with the same reference.
module pulse_modulator
  import pulse_modulator_pkg::*;
(
  input  logic                         clk100,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [PW-1:0]                phase0,
  input  logic [PW-1:0]                phase_inc,
  input  logic [DW-1:0]                amp,
  input  logic [LEN_W-1:0]             pulse_length,
  output logic [LANES-1:0][DW-1:0]     data_i_out,
  output logic [LANES-1:0][DW-1:0]     data_q_out,
  output logic [LANES-1:0][PW-1:0]     phase_vals,
  output logic                         valid,
  output logic                         busy,
  output logic                         done
);

  logic [1:0]           state_r;
  logic [PW-1:0]        acc_r;
  logic [PW-1:0]        inc_r;
  logic signed [DW-1:0] amp_r;
  logic [LEN_W-1:0]     cnt_r;
  logic                 busy_r;
  logic                 done_r;

  phase_vec_t           ph1_r;
  logic                 v1_r;
  phase_vec_t           ph2_r;
  logic                 v2_r;
  sample_vec_t          lut_cos_s;
  sample_vec_t          lut_sin_s;

  sample_vec_t          data_i_r;
  sample_vec_t          data_q_r;
  phase_vec_t           phase_out_r;
  logic                 valid_r;

  logic signed [2*DW-1:0] prod_i_s [LANES];
  logic signed [2*DW-1:0] prod_q_s [LANES];

  // Control FSM: accepts a request in IDLE, counts beats, waits for the
  // pipeline to empty, then strobes done for one cycle
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      acc_r   <= {PW{1'b0}};
      inc_r   <= {PW{1'b0}};
      amp_r   <= 16'sd0;
      cnt_r   <= {LEN_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            inc_r <= phase_inc;
            amp_r <= amp;
            acc_r <= phase0;
            cnt_r <= pulse_length;
            if (pulse_length == {LEN_W{1'b0}}) begin
              state_r <= ST_DONE;     // empty pulse: only the done strobe
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          acc_r <= acc_r + PW'(LANES) * inc_r;
          cnt_r <= cnt_r - LEN_W'(1);
          if (cnt_r == LEN_W'(1)) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // last beat is in the output register once stages 1 and 2 are empty
          if (!v1_r && !v2_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: per-lane phases of the current beat; stage 2 phase/valid delay
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      ph1_r <= '0;
      v1_r  <= 1'b0;
      ph2_r <= '0;
      v2_r  <= 1'b0;
    end else begin
      v1_r <= (state_r == ST_RUN);
      if (state_r == ST_RUN) begin
        for (int k = 0; k < LANES; k++) begin
          ph1_r[k] <= acc_r + PW'(k) * inc_r;
        end
      end
      ph2_r <= ph1_r;
      v2_r  <= v1_r;
    end
  end

  // Stage 2: one registered cos/sin lookup per lane
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pulse_modulator_sincos_lut u_lut (
      .clk100  (clk100),
      .reset_n (reset_n),
      .phase   (ph1_r[k]),
      .cos_val (lut_cos_s[k]),
      .sin_val (lut_sin_s[k])
    );
  end

  // Full-precision envelope products; cos/sin never hit -32768, so >>>15 fits DW
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_i_s[k] = (2*DW)'($signed(lut_cos_s[k])) * (2*DW)'(amp_r);
      prod_q_s[k] = (2*DW)'($signed(lut_sin_s[k])) * (2*DW)'(amp_r);
    end
  end

  // Stage 3: floor-scaled samples to the outputs, zeroed outside valid beats
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      data_i_r    <= '0;
      data_q_r    <= '0;
      phase_out_r <= '0;
      valid_r     <= 1'b0;
    end else begin
      valid_r <= v2_r;
      if (v2_r) begin
        for (int k = 0; k < LANES; k++) begin
          data_i_r[k] <= DW'(prod_i_s[k] >>> 4'd15);
          data_q_r[k] <= DW'(prod_q_s[k] >>> 4'd15);
        end
        phase_out_r <= ph2_r;
      end else begin
        data_i_r    <= '0;
        data_q_r    <= '0;
        phase_out_r <= '0;
      end
    end
  end

  assign data_i_out = data_i_r;
  assign data_q_out = data_q_r;
  assign phase_vals = phase_out_r;
  assign valid      = valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: doc/pulse_modulator.md
Name: pulse_modulator

Overview:
- Transmit-side counterpart of the readout demodulation multiplier.
- Generates a rectangular, constant-amplitude readout pulse as 5 parallel I/Q DAC samples per clk100 cycle (500 MS/s), upconverted by an internal phase accumulator.
- Exports the per-lane phase alongside the data, so the receive-side multiplier can derotate with an identical phase reference.

Parameters:
LANES, 5, samples per clock
DW, 16, signed sample / amplitude width
PW, 14, phase width (full turn = 2^PW)
LEN_W, 11, pulse length counter width (units: clk100 cycles)

Ports:
clk100  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
phase0  in  PW  starting phase of lane 0, beat 0
phase_inc  in  PW  phase step per sample
amp  in  DW  signed envelope amplitude
pulse_length  in  LEN_W  beats (clk100 cycles) of output
data_i_out  out  [LANES][DW]  I samples, lane 0 earliest in time
data_q_out  out  [LANES][DW]  Q samples
phase_vals  out  [LANES][PW]  lane phases aligned with data
valid  out  1  data/phase beat valid
busy  out  1  pulse in progress
done  out  1  one-cycle completion strobe

Behaviour:
- Clock and reset: one clock, clk100; reset_n is asynchronous, active-low.
- Reset state: all outputs 0, FSM in IDLE, pipeline cleared.
- Reset mid-pulse: outputs drop to 0 immediately; no done is issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
- Start acceptance: start=1 in IDLE at edge E0.
  - Latches phase_inc, amp and L = pulse_length.
  - Sets the accumulator acc = phase0.
  - If L = 0: go to DONE; busy stays low; no valid is ever raised.
  - Otherwise: go to RUN.
- RUN, each cycle, beat n:
  - Stage 1 registers the lane phases p_k = acc + k*phase_inc mod 2^PW, for k = 0..4.
  - acc advances by 5*phase_inc mod 2^PW.
  - After L beats, go to DRAIN.
- Pipeline stages after stage 1:
  - Stage 2: sincos lookup, registered.
  - Stage 3: multiply and round, registered to the outputs.
- Latency: beat n is valid in the cycle after edge E(3+n). valid is high for exactly L consecutive cycles.
- DRAIN: lasts until the last beat has been presented, then go to DONE.
- DONE: done=1 for one cycle, in the cycle after the last valid; then IDLE.
- busy: high from the cycle after E0 through the DONE cycle inclusive.
- start is ignored while busy or in DONE. If start is held high, the next pulse is accepted in the first IDLE cycle after DONE.
- Lookup values: cos_t(p) = round(32767*cos(2*pi*p/2^PW)) and sin_t(p) likewise, 16-bit signed. Table values never reach -32768.
- Output arithmetic:
  - data_i = (amp*cos_t) >>> 15 (32-bit product, arithmetic shift, floor).
  - data_q = (amp*sin_t) >>> 15.
  - Range is provably [-32767, 32767]; no saturation logic.
- When valid=0: data_i_out, data_q_out and phase_vals are forced to 0, so the DAC idles at zero.
- phase_vals: carries p_k delayed 2 cycles, aligned to the same beat as the data.
- Wrap-around: all phase arithmetic is mod 2^PW, with no special handling.

Decomposition:
- Shared package holds:
  - LANES, DW, PW, LEN_W.
  - Typedefs for the sample vector [LANES][DW] and the phase vector [LANES][PW].
  - FSM state enum.
- Sub-module sincos_lut: one per lane.
  - Registered 1-cycle read.
  - Quarter-wave table (2^(PW-2) entries) with symmetry folding.
  - Same rounding rule as the lookup values above.

Test Plan:
- phase0=0, phase_inc=0, amp=16384, L=4, start at E0:
  - valid during cycles after E3..E6, with every data_i lane = 16383 and data_q = 0.
  - done in the cycle after E7; busy high after E0 through that cycle.
- phase0=0, phase_inc=4096, amp=32767, L=2:
  - Beat 0 phase_vals = 0,4096,8192,12288,0; data_i = 32766,0,-32767,0,32766; data_q = 0,32766,0,-32767,0.
  - Beat 1 phase_vals = 4096,8192,12288,0,4096.
- pulse_length=0: done one cycle after acceptance; valid and busy never assert; all outputs stay 0.
- amp=-32768, phase0=8192, phase_inc=0, L=1: data_i = 32767, data_q = 0, with no overflow.
- L=10, reset_n=0 asserted during beat 2:
  - All outputs go to 0 immediately and done never pulses.
  - After release, start with L=1 produces exactly one valid beat and one done.
- start held high continuously with L=3:
  - Pulses repeat back-to-back, the next acceptance in the first IDLE cycle after done.
  - A start pulse during busy causes no second pulse.
